// File: rtl/softusb_txgen.sv
`default_nettype none
// ============================================================================
// Module   : softusb_txgen
// Brief    : USB 1.1 line transmitter. Serialises a valid/ready byte stream
//            into NRZI with bit stuffing, optional SYNC/EOP generation, and
//            full-/low-speed bit timing from parameterised dividers.
// Revision : 1.0 - initial release
// ============================================================================
module softusb_txgen #(
  parameter int FS_DIV    = 4,
  parameter int LS_DIV    = 32,
  parameter int STUFF_LEN = 6,
  parameter int SYNC_AUTO = 1
) (
  input  logic       usb_clk,
  input  logic       usb_rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       low_speed,
  input  logic       generate_eop,
  output logic       txp,
  output logic       txm,
  output logic       txoe
);

  localparam int DIV_W   = $clog2(LS_DIV);
  localparam int STUFF_W = $clog2(STUFF_LEN + 1);

  localparam logic [DIV_W-1:0]   FS_RELOAD = DIV_W'(FS_DIV - 1);
  localparam logic [DIV_W-1:0]   LS_RELOAD = DIV_W'(LS_DIV - 1);
  localparam logic [STUFF_W-1:0] STUFF_MAX = STUFF_W'(STUFF_LEN);
  localparam logic [7:0]         SYNC_BYTE = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_DATA    = 3'd2,
    ST_EOP_SE0 = 3'd3,
    ST_EOP_J   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [6:0]         shift_q, shift_d;      // bits still to send after the one on the line
  logic [2:0]         bit_cnt_q, bit_cnt_d;  // index of the byte bit currently on the line
  logic [STUFF_W-1:0] stuff_cnt_q, stuff_cnt_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               ls_q, ls_d;            // speed latched at packet start
  logic               level_q, level_d;      // NRZI level, 1 = J
  logic               eop_cnt_q, eop_cnt_d;  // SE0 bit periods already sent

  logic               strobe;
  logic [DIV_W-1:0]   reload;
  logic               place;                 // a new data/SYNC bit goes on the line
  logic               bit_val;
  logic [STUFF_W-1:0] cnt_base;
  logic               lvl_base;
  logic [7:0]         first_byte;
  logic               line_hi;

  assign reload = ls_q ? LS_RELOAD : FS_RELOAD;
  assign strobe = (state_q != ST_IDLE) && (div_cnt_q == '0);

  // Next-state, bit timing, NRZI/stuffing and the tx_ready strobe
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    stuff_cnt_d = stuff_cnt_q;
    div_cnt_d   = div_cnt_q;
    ls_d        = ls_q;
    level_d     = level_q;
    eop_cnt_d   = eop_cnt_q;
    tx_ready    = 1'b0;
    place       = 1'b0;
    bit_val     = 1'b0;
    first_byte  = SYNC_BYTE;
    // A packet starts from J with no ones counted
    cnt_base    = (state_q == ST_IDLE) ? '0 : stuff_cnt_q;
    lvl_base    = (state_q == ST_IDLE) ? 1'b1 : level_q;

    if (state_q != ST_IDLE) begin
      div_cnt_d = strobe ? reload : div_cnt_q - 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        level_d = 1'b1;
        if (tx_valid) begin
          ls_d      = low_speed;
          div_cnt_d = low_speed ? LS_RELOAD : FS_RELOAD;
          bit_cnt_d = '0;
          if (SYNC_AUTO != 0) begin
            first_byte = SYNC_BYTE;
            state_d    = ST_SYNC;
          end else begin
            first_byte = tx_data;
            tx_ready   = 1'b1;
            state_d    = ST_DATA;
          end
          shift_d = first_byte[7:1];
          place   = 1'b1;
          bit_val = first_byte[0];
        end
      end

      ST_SYNC, ST_DATA: begin
        if (strobe) begin
          if (stuff_cnt_q == STUFF_MAX) begin
            // Stuffed zero: toggle, shift register holds for this slot
            level_d     = ~level_q;
            stuff_cnt_d = '0;
          end else if (bit_cnt_q != 3'd7) begin
            shift_d   = {1'b0, shift_q[6:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            place     = 1'b1;
            bit_val   = shift_q[0];
          end else begin
            tx_ready = 1'b1;
            if (tx_valid) begin
              shift_d   = tx_data[7:1];
              bit_cnt_d = '0;
              state_d   = ST_DATA;
              place     = 1'b1;
              bit_val   = tx_data[0];
            end else if (generate_eop) begin
              state_d   = ST_EOP_SE0;
              eop_cnt_d = 1'b0;
            end else begin
              state_d   = ST_IDLE;
              level_d   = 1'b1;
              div_cnt_d = '0;
            end
          end
        end
      end

      ST_EOP_SE0: begin
        if (strobe) begin
          if (eop_cnt_q) begin
            state_d = ST_EOP_J;
            level_d = 1'b1;
          end else begin
            eop_cnt_d = 1'b1;
          end
        end
      end

      ST_EOP_J: begin
        if (strobe) begin
          state_d   = ST_IDLE;
          div_cnt_d = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (place) begin
      if (bit_val) begin
        stuff_cnt_d = cnt_base + 1'b1;
      end else begin
        stuff_cnt_d = '0;
        level_d     = ~lvl_base;
      end
    end
  end

  // State and datapath registers; reset aborts any packet immediately
  always_ff @(posedge usb_clk or negedge usb_rst_n) begin
    if (!usb_rst_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      stuff_cnt_q <= '0;
      div_cnt_q   <= '0;
      ls_q        <= 1'b0;
      level_q     <= 1'b1;
      eop_cnt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      stuff_cnt_q <= stuff_cnt_d;
      div_cnt_q   <= div_cnt_d;
      ls_q        <= ls_d;
      level_q     <= level_d;
      eop_cnt_q   <= eop_cnt_d;
    end
  end

  // J is (1,0) at full speed and (0,1) at low speed
  assign line_hi = level_q ^ ls_q;
  assign txoe    = (state_q != ST_IDLE);
  assign txp     = (state_q != ST_EOP_SE0) & line_hi;
  assign txm     = (state_q != ST_EOP_SE0) & ~line_hi;

endmodule
`default_nettype wire

// File: tb/tb_softusb_txgen.sv
`default_nettype none
// ============================================================================
// Module   : tb_softusb_txgen
// Brief    : Self-checking bench for softusb_txgen. Expected line symbols are
//            produced by a bit-level NRZI/stuffing model into a scoreboard
//            queue and compared cycle by cycle against the DUT line.
// Revision : 1.0 - initial release
// ============================================================================
module tb_softusb_txgen;

  localparam int FS_DIV    = 4;
  localparam int LS_DIV    = 32;
  localparam int STUFF_LEN = 6;

  typedef logic [7:0] byteq_t [$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic       low_speed = 1'b0;
  logic       gen_eop = 1'b0;
  logic       rdy_a, rdy_b, txp_a, txp_b, txm_a, txm_b, oe_a, oe_b;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         rise_cyc = 0;
  int         fall_cyc = 0;
  int         se0_cnt_b = 0;
  logic [1:0] exp_sym[$];
  int         exp_len[$];
  int         got_rdy[$];

  softusb_txgen #(.FS_DIV(FS_DIV), .LS_DIV(LS_DIV), .STUFF_LEN(STUFF_LEN), .SYNC_AUTO(1)) dut_a (
    .usb_clk(clk), .usb_rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid_a),
    .tx_ready(rdy_a), .low_speed(low_speed), .generate_eop(gen_eop),
    .txp(txp_a), .txm(txm_a), .txoe(oe_a)
  );

  softusb_txgen #(.FS_DIV(FS_DIV), .LS_DIV(LS_DIV), .STUFF_LEN(STUFF_LEN), .SYNC_AUTO(0)) dut_b (
    .usb_clk(clk), .usb_rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid_b),
    .tx_ready(rdy_b), .low_speed(low_speed), .generate_eop(gen_eop),
    .txp(txp_b), .txm(txm_b), .txoe(oe_b)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter for interval measurements
  always @(posedge clk) cyc <= cyc + 1;

  // SE0 observations on the no-EOP instance
  always @(negedge clk) if (oe_b && !txp_b && !txm_b) se0_cnt_b <= se0_cnt_b + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic rdy(input bit sel);
    return sel ? rdy_b : rdy_a;
  endfunction

  function automatic logic oe(input bit sel);
    return sel ? oe_b : oe_a;
  endfunction

  function automatic logic [1:0] line(input bit sel);
    return sel ? {txp_b, txm_b} : {txp_a, txm_a};
  endfunction

  function automatic string q_str(input int q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf(" %0d", q[i])};
    return s;
  endfunction

  // {txp,txm} for a J (j=1) or K (j=0) at the given speed
  function automatic logic [1:0] sym(input bit j, input bit ls);
    if (ls) return j ? 2'b01 : 2'b10;
    else    return j ? 2'b10 : 2'b01;
  endfunction

  // Reference model: expected bit-period symbols of one packet
  task automatic push_packet(input byteq_t bytes, input bit sync, input bit eop, input bit ls);
    byteq_t     all;
    logic [7:0] cur;
    bit         lvl;
    int         ones;
    int         n;
    all  = bytes;
    lvl  = 1'b1;
    ones = 0;
    n    = 0;
    if (sync) all.push_front(8'h80);
    foreach (all[k]) begin
      cur = all[k];
      for (int i = 0; i < 8; i++) begin
        if (cur[i]) ones++;
        else begin
          lvl  = ~lvl;
          ones = 0;
        end
        exp_sym.push_back(sym(lvl, ls));
        n++;
        if (ones == STUFF_LEN) begin
          lvl  = ~lvl;
          ones = 0;
          exp_sym.push_back(sym(lvl, ls));
          n++;
        end
      end
    end
    if (eop) begin
      exp_sym.push_back(2'b00);
      exp_sym.push_back(2'b00);
      exp_sym.push_back(sym(1'b1, ls));
      n += 3;
    end
    exp_len.push_back(n);
  endtask

  task automatic set_valid(input bit sel, input logic v);
    if (sel) valid_b = v;
    else     valid_a = v;
  endtask

  // Byte source: presents bytes, advances on each consumed tx_ready,
  // returns after the end-of-packet strobe (tx_ready with tx_valid low)
  task automatic drive_bytes(input bit sel, input byteq_t bytes, input bit eop);
    int idx   = 0;
    int guard = 0;
    bit done  = 1'b0;
    gen_eop = eop;
    tx_data = bytes[0];
    set_valid(sel, 1'b1);
    while (!done && guard < 3000) begin
      #1;
      if (rdy(sel)) begin
        if (idx == bytes.size()) done = 1'b1;
        else begin
          @(posedge clk);
          #1;
          idx++;
          if (idx < bytes.size()) tx_data = bytes[idx];
          else set_valid(sel, 1'b0);
        end
      end
      if (!done) begin
        @(negedge clk);
        guard++;
      end
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL driver: end-of-packet tx_ready never seen (%0d of %0d bytes consumed), expected it", idx, bytes.size());
      set_valid(sel, 1'b0);
    end
  endtask

  // Scoreboard consumer: waits for txoe, compares every cycle of every bit
  // period against the popped symbol, records tx_ready consumption edges
  // (edge 0 = the edge on which txoe rose), then expects txoe low.
  task automatic check_packet(input bit sel, input int div, input string name);
    int         n;
    int         guard;
    bit         pre_rdy;
    logic [1:0] cur;
    n       = exp_len.pop_front();
    guard   = 0;
    pre_rdy = 1'b0;
    cur     = 2'b00;
    got_rdy.delete();
    #1;
    while (!oe(sel) && guard < 2000) begin
      pre_rdy = rdy(sel);
      @(negedge clk);
      #1;
      guard++;
    end
    tests++;
    if (!oe(sel)) begin
      fails++;
      $display("FAIL %s start: txoe=%b, expected 1 within %0d cycles", name, oe(sel), guard);
      for (int k = 0; k < n; k++) cur = exp_sym.pop_front();
      return;
    end
    rise_cyc = cyc;
    if (pre_rdy) got_rdy.push_back(0);
    for (int c = 0; c < n * div; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      if (c % div == 0) cur = exp_sym.pop_front();
      tests++;
      if (oe(sel) !== 1'b1 || line(sel) !== cur) begin
        fails++;
        $display("FAIL %s line cycle %0d bit %0d: got txoe=%b txp/txm=%b, expected txoe=1 txp/txm=%b",
                 name, c, c / div, oe(sel), line(sel), cur);
      end
      if (rdy(sel)) got_rdy.push_back(c + 1);
    end
    @(negedge clk);
    #1;
    tests++;
    if (oe(sel) !== 1'b0) begin
      fails++;
      $display("FAIL %s txoe fall: got %b at cycle %0d, expected 0", name, oe(sel), n * div);
    end
    fall_cyc = cyc;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({oe_a, txp_a, txm_a, rdy_a} !== 4'b0100) begin
      fails++;
      $display("FAIL reset_a: got oe/p/m/rdy=%b, expected 0100", {oe_a, txp_a, txm_a, rdy_a});
    end
    tests++;
    if ({oe_b, txp_b, txm_b, rdy_b} !== 4'b0100) begin
      fails++;
      $display("FAIL reset_b: got oe/p/m/rdy=%b, expected 0100", {oe_b, txp_b, txm_b, rdy_b});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({oe_a, txp_a, txm_a, rdy_a} !== 4'b0100) begin
      fails++;
      $display("FAIL idle_a: got oe/p/m/rdy=%b, expected 0100", {oe_a, txp_a, txm_a, rdy_a});
    end
  endtask

  task automatic test_fs_single();
    byteq_t b;
    b = {8'hC3};
    low_speed = 1'b0;
    push_packet(b, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    fork
      drive_bytes(1'b0, b, 1'b1);
      check_packet(1'b0, FS_DIV, "fs_single");
    join
    tests++;
    if (got_rdy.size() != 2 || got_rdy[0] != 32 || got_rdy[1] != 64) begin
      fails++;
      $display("FAIL fs_single ready edges: got%s, expected 32 64", q_str(got_rdy));
    end
    tests++;
    if (fall_cyc - rise_cyc != 76) begin
      fails++;
      $display("FAIL fs_single txoe length: got %0d, expected 76", fall_cyc - rise_cyc);
    end
  endtask

  task automatic test_stuffing();
    byteq_t b;
    b = {8'hFF, 8'h00};
    push_packet(b, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    fork
      drive_bytes(1'b0, b, 1'b1);
      check_packet(1'b0, FS_DIV, "stuffing");
    join
    tests++;
    if (got_rdy.size() != 3 || got_rdy[0] != 32 || got_rdy[1] != 68 || got_rdy[2] != 100) begin
      fails++;
      $display("FAIL stuffing ready edges: got%s, expected 32 68 100", q_str(got_rdy));
    end
  endtask

  task automatic test_low_speed();
    byteq_t b;
    b = {8'h01};
    @(negedge clk);
    tests++;
    if ({txp_a, txm_a} !== 2'b10) begin
      fails++;
      $display("FAIL ls idle before: got txp/txm=%b, expected 10", {txp_a, txm_a});
    end
    low_speed = 1'b1;
    push_packet(b, 1'b1, 1'b1, 1'b1);
    fork
      drive_bytes(1'b0, b, 1'b1);
      check_packet(1'b0, LS_DIV, "low_speed");
    join
    tests++;
    if (fall_cyc - rise_cyc != 608) begin
      fails++;
      $display("FAIL low_speed txoe length: got %0d, expected 608", fall_cyc - rise_cyc);
    end
    tests++;
    if ({oe_a, txp_a, txm_a} !== 3'b001) begin
      fails++;
      $display("FAIL ls idle after: got oe/p/m=%b, expected 001", {oe_a, txp_a, txm_a});
    end
    tests++;
    if (got_rdy.size() != 2 || got_rdy[0] != 256 || got_rdy[1] != 512) begin
      fails++;
      $display("FAIL low_speed ready edges: got%s, expected 256 512", q_str(got_rdy));
    end
    low_speed = 1'b0;
  endtask

  task automatic test_no_sync();
    byteq_t b;
    b = {8'h80, 8'h56};
    se0_cnt_b = 0;
    push_packet(b, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    fork
      drive_bytes(1'b1, b, 1'b0);
      check_packet(1'b1, FS_DIV, "no_sync");
    join
    tests++;
    if (got_rdy.size() != 3 || got_rdy[0] != 0 || got_rdy[1] != 32 || got_rdy[2] != 64) begin
      fails++;
      $display("FAIL no_sync ready edges: got%s, expected 0 32 64", q_str(got_rdy));
    end
    tests++;
    if (fall_cyc - rise_cyc != 64) begin
      fails++;
      $display("FAIL no_sync txoe length: got %0d, expected 64", fall_cyc - rise_cyc);
    end
    tests++;
    if (se0_cnt_b != 0) begin
      fails++;
      $display("FAIL no_sync se0: got %0d SE0 cycles, expected 0", se0_cnt_b);
    end
  endtask

  task automatic test_reset_midpacket();
    byteq_t b;
    int     guard = 0;
    tx_data = 8'hC2;
    gen_eop = 1'b1;
    @(negedge clk);
    valid_a = 1'b1;
    #1;
    while (!oe_a && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    tests++;
    if (!oe_a) begin
      fails++;
      $display("FAIL midreset start: txoe=%b, expected 1", oe_a);
    end
    repeat (35) @(negedge clk);
    valid_a = 1'b0;
    repeat (6) @(negedge clk);
    // Cycle 41: third data bit of 0xC2 is a K
    #1;
    tests++;
    if ({oe_a, txp_a, txm_a} !== 3'b101) begin
      fails++;
      $display("FAIL midreset pre: got oe/p/m=%b, expected 101", {oe_a, txp_a, txm_a});
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({oe_a, txp_a, txm_a, rdy_a} !== 4'b0100) begin
      fails++;
      $display("FAIL midreset async: got oe/p/m/rdy=%b, expected 0100", {oe_a, txp_a, txm_a, rdy_a});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    b = {8'h3C};
    push_packet(b, 1'b1, 1'b1, 1'b0);
    fork
      drive_bytes(1'b0, b, 1'b1);
      check_packet(1'b0, FS_DIV, "after_reset");
    join
    tests++;
    if (got_rdy.size() != 2 || got_rdy[0] != 32 || got_rdy[1] != 64) begin
      fails++;
      $display("FAIL after_reset ready edges: got%s, expected 32 64", q_str(got_rdy));
    end
  endtask

  task automatic test_back_to_back();
    byteq_t b1, b2;
    int     rdy1[$];
    int     fall1;
    b1 = {8'hF8};
    b2 = {8'hFF};
    fall1 = 0;
    push_packet(b1, 1'b1, 1'b1, 1'b0);
    push_packet(b2, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    fork
      begin
        drive_bytes(1'b0, b1, 1'b1);
        // Raise tx_valid again while the first EOP is still on the line
        repeat (3) @(negedge clk);
        drive_bytes(1'b0, b2, 1'b1);
      end
      begin
        check_packet(1'b0, FS_DIV, "b2b_first");
        rdy1  = got_rdy;
        fall1 = fall_cyc;
        check_packet(1'b0, FS_DIV, "b2b_second");
      end
    join
    tests++;
    if (rise_cyc - fall1 != 1) begin
      fails++;
      $display("FAIL b2b gap: got %0d idle cycles, expected 1", rise_cyc - fall1);
    end
    tests++;
    if (rdy1.size() != 2 || rdy1[0] != 32 || rdy1[1] != 64) begin
      fails++;
      $display("FAIL b2b first ready edges: got%s, expected 32 64", q_str(rdy1));
    end
    tests++;
    if (got_rdy.size() != 2 || got_rdy[0] != 32 || got_rdy[1] != 68) begin
      fails++;
      $display("FAIL b2b second ready edges: got%s, expected 32 68", q_str(got_rdy));
    end
  endtask

  initial begin
    test_reset();
    test_fs_single();
    test_stuffing();
    test_low_speed();
    test_no_sync();
    test_reset_midpacket();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
